// File: rtl/display_scan_ctrl_pkg.sv
// Shared types and constants for the seven-segment digit scan sequencer.
// Holds the FSM state enum, the blank code and the counter widths.
package disp_pkg;
  typedef enum logic [1:0] {
    IDLE,
    LIT,
    DARK
  } state_t;

  localparam logic [3:0] BLANK_CODE = 4'd8;
  localparam int NUM_DIGITS = 8;
  localparam int DIGIT_W = 3;
  localparam int PHASE_W = 4;
  localparam logic [PHASE_W-1:0] PHASE_LAST = '1;
endpackage

// File: rtl/display_scan_ctrl_if.sv
// Scan sequencer bus: enable/mask/brightness in, control/frame_tick/busy out.
// master drives the configuration, slave is the sequencer itself.
interface display_scan_ctrl_if
  import disp_pkg::*;
();
  logic               enable;
  logic [7:0]         digit_mask;
  logic [PHASE_W-1:0] brightness;
  logic [3:0]         control;
  logic               frame_tick;
  logic               busy;

  modport master (
    output enable, digit_mask, brightness,
    input  control, frame_tick, busy
  );

  modport slave (
    input  enable, digit_mask, brightness,
    output control, frame_tick, busy
  );
endinterface

// File: rtl/display_scan_ctrl_next_digit_sel.sv
// Cyclic priority search for the next enabled digit after cur.
// first=1 returns the lowest set bit; wrap flags nxt<=cur; none flags mask==0.
module next_digit_sel
  import disp_pkg::*;
(
  input  logic [DIGIT_W-1:0] cur,
  input  logic [7:0]         mask,
  input  logic               first,
  output logic [DIGIT_W-1:0] nxt,
  output logic               wrap,
  output logic               none
);
  logic               found;
  logic [DIGIT_W-1:0] idx;

  always_comb begin
    nxt   = cur;
    found = 1'b0;
    idx   = '0;
    none  = (mask == 8'd0);
    for (int i = 0; i < NUM_DIGITS; i++) begin
      idx = first ? DIGIT_W'(i) : cur + DIGIT_W'(i + 1);
      if (!found && mask[idx]) begin
        nxt   = idx;
        found = 1'b1;
      end
    end
    // single-bit mask lands back on cur, which counts as a wrap
    wrap = !first && !none && (nxt <= cur);
  end
endmodule

// File: rtl/display_scan_ctrl.sv
// Digit scan sequencer: time-multiplexes enabled digits with 16-phase PWM.
// Ports: clk, reset (async high), bus (slave: enable/mask/brightness -> control/frame_tick/busy).
module display_scan_ctrl
  import disp_pkg::*;
#(
  parameter int PHASE_CYCLES = 781
) (
  input  logic clk,
  input  logic reset,
  display_scan_ctrl_if.slave bus
);
  localparam int CW = (PHASE_CYCLES > 1) ? $clog2(PHASE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(PHASE_CYCLES - 1);

  state_t             state, state_d;
  logic [DIGIT_W-1:0] digit, digit_d;
  logic [PHASE_W-1:0] phase, phase_d;
  logic [PHASE_W-1:0] bright_q, bright_d;
  logic [CW-1:0]      cnt, cnt_d;
  logic               wrap_d;
  logic [3:0]         control_d;
  logic               frame_d;
  logic               busy_d;

  logic               cnt_wrap;
  logic               slot_end;
  logic [DIGIT_W-1:0] sel_nxt;
  logic               sel_wrap;
  logic               sel_none;

  next_digit_sel u_sel (
    .cur   (digit),
    .mask  (bus.digit_mask),
    .first (state == IDLE),
    .nxt   (sel_nxt),
    .wrap  (sel_wrap),
    .none  (sel_none)
  );

  assign cnt_wrap = (cnt == CNT_MAX);
  assign slot_end = cnt_wrap && (phase == PHASE_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      digit          <= '0;
      phase          <= '0;
      cnt            <= '0;
      bright_q       <= '0;
      bus.control    <= BLANK_CODE;
      bus.frame_tick <= 1'b0;
      bus.busy       <= 1'b0;
    end else begin
      state          <= state_d;
      digit          <= digit_d;
      phase          <= phase_d;
      cnt            <= cnt_d;
      bright_q       <= bright_d;
      bus.control    <= control_d;
      bus.frame_tick <= frame_d;
      bus.busy       <= busy_d;
    end
  end

  always_comb begin
    state_d  = state;
    digit_d  = digit;
    phase_d  = phase;
    cnt_d    = cnt;
    bright_d = bright_q;
    wrap_d   = 1'b0;
    if (!bus.enable) begin
      state_d = IDLE;
      phase_d = '0;
      cnt_d   = '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (!sel_none) begin
            state_d  = LIT;
            digit_d  = sel_nxt;
            bright_d = bus.brightness;
            phase_d  = '0;
            cnt_d    = '0;
          end
        end
        LIT, DARK: begin
          if (slot_end) begin
            phase_d = '0;
            cnt_d   = '0;
            if (sel_none) begin
              state_d = IDLE;
            end else begin
              state_d  = LIT;
              digit_d  = sel_nxt;
              bright_d = bus.brightness;
              wrap_d   = sel_wrap;
            end
          end else begin
            cnt_d = cnt_wrap ? '0 : cnt + 1'b1;
            if (cnt_wrap) phase_d = phase + 1'b1;
            // leave LIT once the last on-phase completes
            if (state == LIT && cnt_wrap && phase == bright_q)
              state_d = DARK;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    control_d = (state_d == LIT) ? {1'b0, digit_d} : BLANK_CODE;
    busy_d    = (state_d != IDLE);
    frame_d   = wrap_d;
  end
endmodule

// File: tb/tb_display_scan_ctrl.sv
// Randomised bench for display_scan_ctrl against a slot-level model.
// Directed scenarios pin the model with literal expectations.
module tb_display_scan_ctrl;
  localparam int PC = 2;
  localparam int SLOT = 16 * PC;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   passed = 0;
  int   total = 0;
  bit   done = 1'b0;

  display_scan_ctrl_if bus ();

  display_scan_ctrl #(.PHASE_CYCLES(PC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(string name, int act, int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  function automatic int lowest(logic [7:0] m);
    for (int i = 0; i < 8; i++) if (m[i]) return i;
    return 0;
  endfunction

  function automatic int next_dig(int cur, logic [7:0] m);
    for (int k = 1; k <= 8; k++) if (m[(cur + k) % 8]) return (cur + k) % 8;
    return cur;
  endfunction

  // model: active flag, digit, cycle within slot, latched brightness
  bit m_act = 1'b0;
  int m_dig = 0;
  int m_sc = 0;
  int m_bq = 0;
  int m_ctl = 8;
  int m_ft = 0;
  int m_busy = 0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_act  <= 1'b0;
      m_ctl  <= 8;
      m_ft   <= 0;
      m_busy <= 0;
    end else begin
      automatic bit a = m_act;
      automatic int d = m_dig;
      automatic int s = m_sc;
      automatic int b = m_bq;
      automatic int f = 0;
      automatic int nd;
      if (!bus.enable) begin
        a = 1'b0;
      end else if (!a) begin
        if (bus.digit_mask != 0) begin
          a = 1'b1;
          d = lowest(bus.digit_mask);
          b = int'(bus.brightness);
          s = 0;
        end
      end else if (s == SLOT - 1) begin
        if (bus.digit_mask == 0) begin
          a = 1'b0;
        end else begin
          nd = next_dig(d, bus.digit_mask);
          f = (nd <= d) ? 1 : 0;
          d = nd;
          b = int'(bus.brightness);
          s = 0;
        end
      end else begin
        s = s + 1;
      end
      m_act  <= a;
      m_dig  <= d;
      m_sc   <= s;
      m_bq   <= b;
      m_ft   <= f;
      m_busy <= a ? 1 : 0;
      m_ctl  <= (a && s < (b + 1) * PC) ? d : 8;
    end
  end

  always @(negedge clk) begin
    if (!done) begin
      chk("cmp_control", int'(bus.control), m_ctl);
      chk("cmp_frame_tick", int'(bus.frame_tick), m_ft);
      chk("cmp_busy", int'(bus.busy), m_busy);
    end
  end

  task automatic cyc(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic restart(logic [7:0] m, logic [3:0] br);
    bus.enable = 1'b0;
    cyc(1);
    bus.digit_mask = m;
    bus.brightness = br;
    bus.enable = 1'b1;
    cyc(1);
  endtask

  int r;
  int exp_dig[5] = '{0, 2, 7, 0, 2};

  initial begin
    bus.enable = 1'b1;
    bus.digit_mask = 8'hFF;
    bus.brightness = 4'd15;
    #1 reset = 1'b1;
    cyc(2);
    chk("rst_control", int'(bus.control), 8);
    chk("rst_frame_tick", int'(bus.frame_tick), 0);
    chk("rst_busy", int'(bus.busy), 0);
    reset = 1'b0;
    cyc(1);
    chk("first_digit", int'(bus.control), 0);
    chk("first_busy", int'(bus.busy), 1);
    chk("first_no_tick", int'(bus.frame_tick), 0);
    for (int n = 1; n <= 8 * SLOT + 1; n++) begin
      cyc(1);
      if (n % SLOT == 0) chk("ff_seq", int'(bus.control), (n / SLOT) % 8);
      if (n == SLOT - 1) chk("ff_hold", int'(bus.control), 0);
      if (n >= 8 * SLOT - 1)
        chk("ff_tick", int'(bus.frame_tick), (n == 8 * SLOT) ? 1 : 0);
    end

    restart(8'h01, 4'd3);
    chk("pwm_c0", int'(bus.control), 0);
    chk("pwm_t0", int'(bus.frame_tick), 0);
    cyc(7);
    chk("pwm_c7", int'(bus.control), 0);
    cyc(1);
    chk("pwm_c8", int'(bus.control), 8);
    chk("pwm_busy_dark", int'(bus.busy), 1);
    cyc(23);
    chk("pwm_c31", int'(bus.control), 8);
    cyc(1);
    chk("pwm_c32", int'(bus.control), 0);
    chk("pwm_t32", int'(bus.frame_tick), 1);
    cyc(1);
    chk("pwm_t33", int'(bus.frame_tick), 0);

    restart(8'b1000_0101, 4'd15);
    chk("skip_0", int'(bus.control), 0);
    for (int s = 1; s < 5; s++) begin
      cyc(SLOT);
      chk("skip_seq", int'(bus.control), exp_dig[s]);
      chk("skip_tick", int'(bus.frame_tick), (s == 3) ? 1 : 0);
    end

    restart(8'h05, 4'd15);
    cyc(40);
    bus.digit_mask = 8'h00;
    cyc(23);
    chk("mask0_hold", int'(bus.control), 2);
    cyc(1);
    chk("mask0_blank", int'(bus.control), 8);
    chk("mask0_busy", int'(bus.busy), 0);
    bus.digit_mask = 8'h10;
    cyc(1);
    chk("mask10_ctl", int'(bus.control), 4);
    chk("mask10_busy", int'(bus.busy), 1);

    restart(8'h20, 4'd2);
    cyc(10);
    chk("dark5_ctl", int'(bus.control), 8);
    chk("dark5_busy", int'(bus.busy), 1);
    bus.enable = 1'b0;
    cyc(1);
    chk("dis_ctl", int'(bus.control), 8);
    chk("dis_busy", int'(bus.busy), 0);
    bus.enable = 1'b1;
    cyc(2);
    chk("relit_ctl", int'(bus.control), 5);
    #2 reset = 1'b1;
    #1;
    chk("async_ctl", int'(bus.control), 8);
    chk("async_busy", int'(bus.busy), 0);
    @(negedge clk);
    reset = 1'b0;
    cyc(1);
    chk("post_rst_ctl", int'(bus.control), 5);

    repeat (4000) begin
      @(negedge clk);
      r = $urandom_range(0, 199);
      if (r < 4) bus.digit_mask = 8'($urandom_range(0, 255));
      else if (r == 4) bus.digit_mask = 8'h00;
      else if (r < 9) bus.brightness = 4'($urandom_range(0, 15));
      else if (r == 9) bus.enable = ~bus.enable;
      else if (r < 14 && !bus.enable) bus.enable = 1'b1;
      else if (r == 14 && $urandom_range(0, 3) == 0) begin
        #2 reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
      end
    end

    @(negedge clk);
    done = 1'b1;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
